// File: rtl/insn_decode_imm.sv
// ARMv8 subset classifier: combinational opcode/immediate for fetch steering,
// plus a one-entry output register feeding decode on the following cycle.
module insn_decode_imm #(
  parameter int GPR_SIZE = 64
) (
  input  logic                in_clk,
  input  logic                rst,
  input  logic [31:0]         in_insnbits,
  input  logic                in_valid,
  input  logic                in_stall,
  output logic [4:0]          out_opcode,
  output logic [GPR_SIZE-1:0] out_imm,
  output logic [4:0]          out_q_opcode,
  output logic [GPR_SIZE-1:0] out_q_imm,
  output logic                out_q_valid
);

  localparam logic [4:0] OP_ERROR = 5'd0,  OP_LDUR  = 5'd1,  OP_STUR  = 5'd2,
                         OP_MOVK  = 5'd3,  OP_MOVZ  = 5'd4,  OP_ADR   = 5'd5,
                         OP_ADRP  = 5'd6,  OP_CSEL  = 5'd7,  OP_CSINC = 5'd8,
                         OP_CSINV = 5'd9,  OP_CSNEG = 5'd10, OP_ADDS  = 5'd11,
                         OP_SUBS  = 5'd12, OP_MVN   = 5'd13, OP_ORR   = 5'd14,
                         OP_EOR   = 5'd15, OP_ANDS  = 5'd16, OP_LSL   = 5'd17,
                         OP_LSR   = 5'd18, OP_UBFM  = 5'd19, OP_ASR   = 5'd20,
                         OP_B     = 5'd21, OP_BR    = 5'd22, OP_BCOND = 5'd23,
                         OP_BL    = 5'd24, OP_BLR   = 5'd25, OP_RET   = 5'd26,
                         OP_NOP   = 5'd27, OP_HLT   = 5'd28;

  logic [31:0] i;
  logic [5:0]  immr, imms;
  logic [4:0]  opcode_d, opcode_q;
  logic [GPR_SIZE-1:0] imm_d, imm_q;
  logic        valid_d, valid_q;

  assign i    = in_insnbits;
  assign immr = i[21:16];
  assign imms = i[15:10];

  // Keys are mutually exclusive, so the if-chain order carries no priority.
  always_comb begin
    out_opcode = OP_ERROR;
    out_imm    = '0;
    if (i[31:21] == 11'b11111000010) begin
      out_opcode = OP_LDUR;
      out_imm    = {{(GPR_SIZE-9){i[20]}}, i[20:12]};
    end else if (i[31:21] == 11'b11111000000) begin
      out_opcode = OP_STUR;
      out_imm    = {{(GPR_SIZE-9){i[20]}}, i[20:12]};
    end else if (i[31:23] == 9'b110100101) begin
      out_opcode = OP_MOVZ;
      out_imm    = {{(GPR_SIZE-16){1'b0}}, i[20:5]};
    end else if (i[31:23] == 9'b111100101) begin
      out_opcode = OP_MOVK;
      out_imm    = {{(GPR_SIZE-16){1'b0}}, i[20:5]};
    end else if (i[28:24] == 5'b10000) begin
      out_opcode = i[31] ? OP_ADRP : OP_ADR;
      out_imm    = {{(GPR_SIZE-21){i[23]}}, i[23:5], i[30:29]};
      if (i[31]) out_imm = out_imm << 12;
    end else if (i[31:23] == 9'b101100010 || i[31:23] == 9'b111100010) begin
      out_opcode = i[30] ? OP_SUBS : OP_ADDS;
      out_imm    = {{(GPR_SIZE-12){1'b0}}, i[21:10]};
      if (i[22]) out_imm = out_imm << 12;
    end else if (i[31:21] == 11'b10101011000) begin
      out_opcode = OP_ADDS;
    end else if (i[31:21] == 11'b11101011000) begin
      out_opcode = OP_SUBS;
    end else if (i[31:21] == 11'b11101010000) begin
      out_opcode = OP_ANDS;
    end else if (i[31:21] == 11'b10101010000) begin
      out_opcode = OP_ORR;
    end else if (i[31:21] == 11'b11001010000) begin
      out_opcode = OP_EOR;
    end else if (i[31:21] == 11'b10101010001) begin
      out_opcode = OP_MVN;
    end else if (i[31:21] == 11'b10011010100 && i[11] == 1'b0) begin
      out_opcode = i[10] ? OP_CSINC : OP_CSEL;
    end else if (i[31:21] == 11'b11011010100 && i[11] == 1'b0) begin
      out_opcode = i[10] ? OP_CSNEG : OP_CSINV;
    end else if (i[31:22] == 10'b1101001101) begin
      // UBFM aliases: LSR when imms saturates, LSL when immr == imms+1.
      if (imms == 6'd63) begin
        out_opcode = OP_LSR;
        out_imm    = {{(GPR_SIZE-6){1'b0}}, immr};
      end else if ({1'b0, imms} + 7'd1 == {1'b0, immr}) begin
        out_opcode = OP_LSL;
        out_imm    = {{(GPR_SIZE-6){1'b0}}, 6'd63 - imms};
      end else begin
        out_opcode = OP_UBFM;
        out_imm    = {{(GPR_SIZE-12){1'b0}}, immr, imms};
      end
    end else if (i[31:22] == 10'b1001001101 && imms == 6'd63) begin
      out_opcode = OP_ASR;
      out_imm    = {{(GPR_SIZE-6){1'b0}}, immr};
    end else if (i[30:26] == 5'b00101) begin
      out_opcode = i[31] ? OP_BL : OP_B;
      out_imm    = {{(GPR_SIZE-28){i[25]}}, i[25:0], 2'b00};
    end else if (i[31:24] == 8'b01010100 && !i[4]) begin
      out_opcode = OP_BCOND;
      out_imm    = {{(GPR_SIZE-21){i[23]}}, i[23:5], 2'b00};
    end else if (i[31:10] == 22'b1101011000011111000000 && i[4:0] == 5'd0) begin
      out_opcode = OP_BR;
    end else if (i[31:10] == 22'b1101011000111111000000 && i[4:0] == 5'd0) begin
      out_opcode = OP_BLR;
    end else if (i[31:10] == 22'b1101011001011111000000 && i[4:0] == 5'd0) begin
      out_opcode = OP_RET;
    end else if (i == 32'hD503201F) begin
      out_opcode = OP_NOP;
    end else if (i[31:21] == 11'b11010100010 && i[4:0] == 5'd0) begin
      out_opcode = OP_HLT;
    end
  end

  always_comb begin
    opcode_d = opcode_q;
    imm_d    = imm_q;
    valid_d  = valid_q;
    if (!in_stall) begin
      opcode_d = out_opcode;
      imm_d    = out_imm;
      valid_d  = in_valid;
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      opcode_q <= OP_ERROR;
      imm_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      valid_q  <= valid_d;
    end
  end

  assign out_q_opcode = opcode_q;
  assign out_q_imm    = imm_q;
  assign out_q_valid  = valid_q;

endmodule

// File: tb/tb_insn_decode_imm.sv
// Directed-vector bench for insn_decode_imm: combinational decode table and
// the registered stage (reset, load, stall, valid-low, reset-over-stall).
module tb_insn_decode_imm;
  logic        in_clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_insnbits = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_stall = 1'b0;
  logic [4:0]  out_opcode, out_q_opcode;
  logic [63:0] out_imm, out_q_imm;
  logic        out_q_valid;
  int checks = 0;
  int failures = 0;

  insn_decode_imm #(.GPR_SIZE(64)) dut (
    .in_clk(in_clk), .rst(rst), .in_insnbits(in_insnbits), .in_valid(in_valid),
    .in_stall(in_stall), .out_opcode(out_opcode), .out_imm(out_imm),
    .out_q_opcode(out_q_opcode), .out_q_imm(out_q_imm), .out_q_valid(out_q_valid)
  );

  always #5 in_clk = ~in_clk;

  task automatic test_branch();
    logic [31:0] v [0:6];
    logic [4:0]  op[0:6];
    logic [63:0] im[0:6];
    v  = '{32'h14000003, 32'h17FFFFFF, 32'h94000001, 32'h54000041,
           32'h54000050, 32'hD61F0000, 32'hD63F0000};
    op = '{5'd21, 5'd21, 5'd24, 5'd23, 5'd0, 5'd22, 5'd25};
    im = '{64'd12, 64'hFFFFFFFFFFFFFFFC, 64'd4, 64'd8, 64'd0, 64'd0, 64'd0};
    for (int k = 0; k < 7; k++) begin
      in_insnbits = v[k]; #1;
      checks++;
      if (out_opcode !== op[k] || out_imm !== im[k]) begin
        failures++;
        $display("FAIL branch insn=%h got op=%0d imm=%h want op=%0d imm=%h",
                 v[k], out_opcode, out_imm, op[k], im[k]);
      end
    end
  endtask

  task automatic test_mem_mov_adr();
    logic [31:0] v [0:6];
    logic [4:0]  op[0:6];
    logic [63:0] im[0:6];
    v  = '{32'hF85F8041, 32'hF8010041, 32'hD2800020, 32'hF2A00020,
           32'hB0000000, 32'h30000000, 32'h10FFFFE0};
    op = '{5'd1, 5'd2, 5'd4, 5'd3, 5'd6, 5'd5, 5'd5};
    im = '{64'hFFFFFFFFFFFFFFF8, 64'd16, 64'd1, 64'd1, 64'h1000, 64'd1,
           64'hFFFFFFFFFFFFFFFC};
    for (int k = 0; k < 7; k++) begin
      in_insnbits = v[k]; #1;
      checks++;
      if (out_opcode !== op[k] || out_imm !== im[k]) begin
        failures++;
        $display("FAIL mem_mov_adr insn=%h got op=%0d imm=%h want op=%0d imm=%h",
                 v[k], out_opcode, out_imm, op[k], im[k]);
      end
    end
  endtask

  task automatic test_alu_shift();
    logic [31:0] v [0:9];
    logic [4:0]  op[0:9];
    logic [63:0] im[0:9];
    v  = '{32'hD344FC20, 32'hD37CEC20, 32'h9344FC20, 32'hD3410C20, 32'h93440C20,
           32'hB1400421, 32'hF1000421, 32'h9A820020, 32'hDA820420, 32'hAA2203E1};
    op = '{5'd18, 5'd17, 5'd20, 5'd19, 5'd0, 5'd11, 5'd12, 5'd7, 5'd10, 5'd13};
    im = '{64'd4, 64'd4, 64'd4, 64'h43, 64'd0, 64'h1000, 64'd1, 64'd0, 64'd0, 64'd0};
    for (int k = 0; k < 10; k++) begin
      in_insnbits = v[k]; #1;
      checks++;
      if (out_opcode !== op[k] || out_imm !== im[k]) begin
        failures++;
        $display("FAIL alu_shift insn=%h got op=%0d imm=%h want op=%0d imm=%h",
                 v[k], out_opcode, out_imm, op[k], im[k]);
      end
    end
  endtask

  task automatic test_sys_error();
    logic [31:0] v [0:4];
    logic [4:0]  op[0:4];
    v  = '{32'hD4400000, 32'hD503201F, 32'hD65F03C0, 32'h00000000, 32'hFFFFFFFF};
    op = '{5'd28, 5'd27, 5'd26, 5'd0, 5'd0};
    for (int k = 0; k < 5; k++) begin
      in_insnbits = v[k]; #1;
      checks++;
      if (out_opcode !== op[k] || out_imm !== 64'd0) begin
        failures++;
        $display("FAIL sys_error insn=%h got op=%0d imm=%h want op=%0d imm=0",
                 v[k], out_opcode, out_imm, op[k]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge in_clk);
    rst = 1'b1; in_valid = 1'b1; in_stall = 1'b0; in_insnbits = 32'h14000003;
    repeat (2) @(posedge in_clk);
    #1;
    checks++;
    if (out_q_valid !== 1'b0 || out_q_opcode !== 5'd0 || out_q_imm !== 64'd0) begin
      failures++;
      $display("FAIL reset got v=%b op=%0d imm=%h want v=0 op=0 imm=0",
               out_q_valid, out_q_opcode, out_q_imm);
    end
    @(negedge in_clk);
    rst = 1'b0;
  endtask

  task automatic test_load_stall();
    in_insnbits = 32'h14000003; in_valid = 1'b1;
    @(posedge in_clk); #1;
    checks++;
    if (out_q_valid !== 1'b1 || out_q_opcode !== 5'd21 || out_q_imm !== 64'd12) begin
      failures++;
      $display("FAIL load got v=%b op=%0d imm=%h want v=1 op=21 imm=c",
               out_q_valid, out_q_opcode, out_q_imm);
    end
    @(negedge in_clk);
    in_stall = 1'b1; in_insnbits = 32'h94000001; in_valid = 1'b0;
    repeat (2) @(posedge in_clk);
    #1;
    checks++;
    if (out_q_valid !== 1'b1 || out_q_opcode !== 5'd21 || out_q_imm !== 64'd12) begin
      failures++;
      $display("FAIL stall_hold got v=%b op=%0d imm=%h want v=1 op=21 imm=c",
               out_q_valid, out_q_opcode, out_q_imm);
    end
    checks++;
    if (out_opcode !== 5'd24 || out_imm !== 64'd4) begin
      failures++;
      $display("FAIL stall_comb got op=%0d imm=%h want op=24 imm=4", out_opcode, out_imm);
    end
    @(negedge in_clk);
    in_stall = 1'b0;
    @(posedge in_clk); #1;
    checks++;
    if (out_q_valid !== 1'b0 || out_q_opcode !== 5'd24 || out_q_imm !== 64'd4) begin
      failures++;
      $display("FAIL valid_low got v=%b op=%0d imm=%h want v=0 op=24 imm=4",
               out_q_valid, out_q_opcode, out_q_imm);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [0:3];
    logic [4:0]  op[0:3];
    logic [63:0] im[0:3];
    logic        vl[0:3];
    v  = '{32'hF85F8041, 32'hB1400421, 32'h54000041, 32'hD344FC20};
    op = '{5'd1, 5'd11, 5'd23, 5'd18};
    im = '{64'hFFFFFFFFFFFFFFF8, 64'h1000, 64'd8, 64'd4};
    vl = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      @(negedge in_clk);
      in_insnbits = v[k]; in_valid = vl[k];
      @(posedge in_clk); #1;
      checks++;
      if (out_q_valid !== vl[k] || out_q_opcode !== op[k] || out_q_imm !== im[k]) begin
        failures++;
        $display("FAIL back_to_back[%0d] got v=%b op=%0d imm=%h want v=%b op=%0d imm=%h",
                 k, out_q_valid, out_q_opcode, out_q_imm, vl[k], op[k], im[k]);
      end
    end
  endtask

  task automatic test_reset_over_stall();
    @(negedge in_clk);
    rst = 1'b1; in_stall = 1'b1; in_valid = 1'b1;
    @(posedge in_clk); #1;
    checks++;
    if (out_q_valid !== 1'b0 || out_q_opcode !== 5'd0 || out_q_imm !== 64'd0) begin
      failures++;
      $display("FAIL reset_stall got v=%b op=%0d imm=%h want v=0 op=0 imm=0",
               out_q_valid, out_q_opcode, out_q_imm);
    end
    @(negedge in_clk);
    rst = 1'b0; in_stall = 1'b0; in_insnbits = 32'h94000001; in_valid = 1'b1;
    @(posedge in_clk); #1;
    checks++;
    if (out_q_valid !== 1'b1 || out_q_opcode !== 5'd24 || out_q_imm !== 64'd4) begin
      failures++;
      $display("FAIL first_load got v=%b op=%0d imm=%h want v=1 op=24 imm=4",
               out_q_valid, out_q_opcode, out_q_imm);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_mem_mov_adr();
    test_alu_shift();
    test_sys_error();
    @(negedge in_clk);
    test_load_stall();
    test_back_to_back();
    test_reset_over_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
